// File: rtl/ascon_pack.sv
// Shared definitions for the ASCON-128 AEAD sequencer.
package ascon_pack;

    localparam int unsigned ROUND_W = 4;
    localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd11;
    // Round index space of the permutation: p^N runs indices 12-N .. 11.
    localparam int unsigned ROUND_SLOTS = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT_AD = 3'd2,
        ST_AD      = 3'd3,
        ST_WAIT_PT = 3'd4,
        ST_PT      = 3'd5,
        ST_FINAL   = 3'd6,
        ST_DONE    = 3'd7
    } ctrl_state_t;

    // Datapath control strobes, registered as one bundle.
    typedef struct packed {
        logic data_sel;
        logic en_reg_state;
        logic en_xor_data;
        logic en_xor_key;
        logic en_xor_key_end;
        logic en_xor_lsb;
        logic en_cipher;
        logic en_tag;
        logic data_ready;
        logic busy;
        logic done;
    } ctrl_out_t;

    // True for states that run the permutation.
    function automatic logic is_perm_state(input ctrl_state_t st);
        return (st == ST_INIT) || (st == ST_AD) || (st == ST_PT) || (st == ST_FINAL);
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round-constant index counter with load, increment and last-round flag.
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               load,
    input  logic [ROUND_W-1:0] load_value,
    input  logic               enable,
    output logic [ROUND_W-1:0] count,
    output logic [ROUND_W-1:0] next_count_c,
    output logic               done
);

    // Next count: load wins over increment.
    always_comb begin
        next_count_c = count;
        if (load) begin
            next_count_c = load_value;
        end else if (enable) begin
            next_count_c = count + ROUND_W'(1);
        end
    end

    // Count register; done flags the last round index in step with count.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= next_count_c;
            done  <= (next_count_c == LAST_ROUND);
        end
    end

endmodule

// File: rtl/ascon_ctrl_fsm_param.sv
// Parametrised ASCON-128 AEAD sequencer driving the ascon datapath enables.
module ascon_ctrl_fsm_param
    import ascon_pack::*;
#(
    parameter int unsigned NB_ROUNDS_A = 12,
    parameter int unsigned NB_ROUNDS_B = 6,
    parameter int unsigned BLOCK_W     = 4
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               decrypt_i,
    input  logic [BLOCK_W-1:0] nb_ad_i,
    input  logic [BLOCK_W-1:0] nb_pt_i,
    input  logic               data_valid_i,
    output logic               data_ready_o,
    output logic [3:0]         round_o,
    output logic [BLOCK_W-1:0] block_o,
    output logic               data_sel_o,
    output logic               en_reg_state_o,
    output logic               en_xor_data_o,
    output logic               en_xor_key_o,
    output logic               en_xor_key_end_o,
    output logic               en_xor_lsb_o,
    output logic               decrypt_mode_o,
    output logic               en_cipher_o,
    output logic               en_tag_o,
    output logic               cipher_valid_o,
    output logic               busy_o,
    output logic               end_o
);

    localparam logic [ROUND_W-1:0] FIRST_A = ROUND_W'(ROUND_SLOTS - NB_ROUNDS_A);
    localparam logic [ROUND_W-1:0] FIRST_B = ROUND_W'(ROUND_SLOTS - NB_ROUNDS_B);

    ctrl_state_t        state;
    ctrl_state_t        state_d;
    logic [BLOCK_W-1:0] block;
    logic [BLOCK_W-1:0] block_d;
    logic [BLOCK_W-1:0] nb_ad;
    logic [BLOCK_W-1:0] nb_ad_d;
    logic [BLOCK_W-1:0] nb_pt;
    logic [BLOCK_W-1:0] nb_pt_d;
    logic               decrypt_d;
    logic               accept;
    logic               last_ad;
    logic               more_pt;

    logic               ctr_load;
    logic [ROUND_W-1:0] ctr_load_value;
    logic               ctr_enable;
    logic [ROUND_W-1:0] round;
    logic [ROUND_W-1:0] round_d;
    logic               round_done;

    ctrl_out_t          ctrl_d;
    ctrl_out_t          ctrl_q;

    assign accept  = data_valid_i & data_ready_o;
    assign last_ad = (block == nb_ad - BLOCK_W'(1));
    assign more_pt = (block < nb_pt - BLOCK_W'(1));

    ascon_round_counter u_round_counter (
        .clock_i      (clock_i),
        .resetb_i     (resetb_i),
        .load         (ctr_load),
        .load_value   (ctr_load_value),
        .enable       (ctr_enable),
        .count        (round),
        .next_count_c (round_d),
        .done         (round_done)
    );

    // State, block counter and sampled transaction parameters.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state          <= ST_IDLE;
            block          <= '0;
            nb_ad          <= '0;
            nb_pt          <= '0;
            decrypt_mode_o <= 1'b0;
        end else begin
            state          <= state_d;
            block          <= block_d;
            nb_ad          <= nb_ad_d;
            nb_pt          <= nb_pt_d;
            decrypt_mode_o <= decrypt_d;
        end
    end

    // Next-state, block counter and parameter sampling; abort overrides all.
    always_comb begin
        state_d   = state;
        block_d   = block;
        nb_ad_d   = nb_ad;
        nb_pt_d   = nb_pt;
        decrypt_d = decrypt_mode_o;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_INIT;
                    block_d   = '0;
                    nb_ad_d   = nb_ad_i;
                    nb_pt_d   = (nb_pt_i == '0) ? BLOCK_W'(1) : nb_pt_i;
                    decrypt_d = decrypt_i;
                end
            end
            ST_INIT: begin
                if (round_done) begin
                    state_d = (nb_ad == '0) ? ST_WAIT_PT : ST_WAIT_AD;
                end
            end
            ST_WAIT_AD: begin
                if (accept) begin
                    state_d = ST_AD;
                end
            end
            ST_AD: begin
                if (round_done) begin
                    if (last_ad) begin
                        block_d = '0;
                        state_d = ST_WAIT_PT;
                    end else begin
                        block_d = block + BLOCK_W'(1);
                        state_d = ST_WAIT_AD;
                    end
                end
            end
            ST_WAIT_PT: begin
                if (accept) begin
                    state_d = more_pt ? ST_PT : ST_FINAL;
                end
            end
            ST_PT: begin
                if (round_done) begin
                    block_d = block + BLOCK_W'(1);
                    state_d = ST_WAIT_PT;
                end
            end
            ST_FINAL: begin
                if (round_done) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d   = ST_IDLE;
            block_d   = '0;
            nb_ad_d   = '0;
            nb_pt_d   = '0;
            decrypt_d = 1'b0;
        end
    end

    // Round counter: count through a permutation, otherwise preload for the next state.
    always_comb begin
        ctr_load       = abort_i || !is_perm_state(state) || round_done;
        ctr_enable     = !ctr_load;
        ctr_load_value = '0;
        case (state_d)
            ST_INIT, ST_FINAL: ctr_load_value = FIRST_A;
            ST_AD, ST_PT:      ctr_load_value = FIRST_B;
            default:           ctr_load_value = '0;
        endcase
    end

    // Strobe decode from next-cycle state, round and block so strobes come from flops.
    always_comb begin
        ctrl_d              = '0;
        ctrl_d.en_reg_state = is_perm_state(state_d);
        ctrl_d.data_ready   = (state_d == ST_WAIT_AD) || (state_d == ST_WAIT_PT);
        ctrl_d.busy         = (state_d != ST_IDLE) && (state_d != ST_DONE);
        ctrl_d.done         = (state_d == ST_DONE);
        case (state_d)
            ST_INIT: begin
                ctrl_d.data_sel       = (round_d == FIRST_A);
                ctrl_d.en_xor_key_end = (round_d == LAST_ROUND);
                ctrl_d.en_xor_lsb     = (round_d == LAST_ROUND) && (nb_ad_d == '0);
            end
            ST_AD: begin
                ctrl_d.en_xor_data = (round_d == FIRST_B);
                ctrl_d.en_xor_lsb  = (round_d == LAST_ROUND) &&
                                     (block_d == nb_ad_d - BLOCK_W'(1));
            end
            ST_PT: begin
                ctrl_d.en_xor_data = (round_d == FIRST_B);
                ctrl_d.en_cipher   = (round_d == FIRST_B);
            end
            ST_FINAL: begin
                ctrl_d.en_xor_data    = (round_d == FIRST_A);
                ctrl_d.en_xor_key     = (round_d == FIRST_A);
                ctrl_d.en_cipher      = (round_d == FIRST_A);
                ctrl_d.en_xor_key_end = (round_d == LAST_ROUND);
                ctrl_d.en_tag         = (round_d == LAST_ROUND);
            end
            default: ;
        endcase
    end

    // Strobe register plus the cipher-valid pulse one cycle behind en_cipher.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            ctrl_q         <= '0;
            cipher_valid_o <= 1'b0;
        end else begin
            ctrl_q         <= ctrl_d;
            cipher_valid_o <= ctrl_q.en_cipher;
        end
    end

    assign round_o          = round;
    assign block_o          = block;
    assign data_sel_o       = ctrl_q.data_sel;
    assign en_reg_state_o   = ctrl_q.en_reg_state;
    assign en_xor_data_o    = ctrl_q.en_xor_data;
    assign en_xor_key_o     = ctrl_q.en_xor_key;
    assign en_xor_key_end_o = ctrl_q.en_xor_key_end;
    assign en_xor_lsb_o     = ctrl_q.en_xor_lsb;
    assign en_cipher_o      = ctrl_q.en_cipher;
    assign en_tag_o         = ctrl_q.en_tag;
    assign data_ready_o     = ctrl_q.data_ready;
    assign busy_o           = ctrl_q.busy;
    assign end_o            = ctrl_q.done;

endmodule

// File: tb/tb_ascon_ctrl_fsm_param.sv
// Directed self-checking bench for the parametrised ASCON sequencer.
module tb_ascon_ctrl_fsm_param;

    localparam int unsigned BLOCK_W = 4;

    logic               clock_i;
    logic               resetb_i;
    logic               start_i;
    logic               abort_i;
    logic               decrypt_i;
    logic [BLOCK_W-1:0] nb_ad_i;
    logic [BLOCK_W-1:0] nb_pt_i;
    logic               data_valid_i;
    logic               data_ready_o;
    logic [3:0]         round_o;
    logic [BLOCK_W-1:0] block_o;
    logic               data_sel_o;
    logic               en_reg_state_o;
    logic               en_xor_data_o;
    logic               en_xor_key_o;
    logic               en_xor_key_end_o;
    logic               en_xor_lsb_o;
    logic               decrypt_mode_o;
    logic               en_cipher_o;
    logic               en_tag_o;
    logic               cipher_valid_o;
    logic               busy_o;
    logic               end_o;

    logic [31:0]        all_outs;

    int n_cmp;
    int n_err;

    // Per-transaction observations.
    int          r_tag_t, r_end_t, r_ciph, r_cv, r_cv_ok, r_lsb, r_lsb_key;
    int          r_ready, r_loads, r_bad_load, r_busy, r_dec, r_abort_round;
    logic [31:0] r_seq, r_abort_outs;
    logic        r_busy_t2, r_end_t2, r_timeout;

    ascon_ctrl_fsm_param #(
        .NB_ROUNDS_A (12),
        .NB_ROUNDS_B (6),
        .BLOCK_W     (BLOCK_W)
    ) dut (
        .clock_i          (clock_i),
        .resetb_i         (resetb_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .decrypt_i        (decrypt_i),
        .nb_ad_i          (nb_ad_i),
        .nb_pt_i          (nb_pt_i),
        .data_valid_i     (data_valid_i),
        .data_ready_o     (data_ready_o),
        .round_o          (round_o),
        .block_o          (block_o),
        .data_sel_o       (data_sel_o),
        .en_reg_state_o   (en_reg_state_o),
        .en_xor_data_o    (en_xor_data_o),
        .en_xor_key_o     (en_xor_key_o),
        .en_xor_key_end_o (en_xor_key_end_o),
        .en_xor_lsb_o     (en_xor_lsb_o),
        .decrypt_mode_o   (decrypt_mode_o),
        .en_cipher_o      (en_cipher_o),
        .en_tag_o         (en_tag_o),
        .cipher_valid_o   (cipher_valid_o),
        .busy_o           (busy_o),
        .end_o            (end_o)
    );

    assign all_outs = {11'd0, round_o, block_o, data_sel_o, en_reg_state_o, en_xor_data_o,
                       en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o, decrypt_mode_o,
                       en_cipher_o, en_tag_o, cipher_valid_o, busy_o, end_o, data_ready_o};

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Start a transaction on the current negedge (cycle 1) and observe until end_o or abort.
    task automatic run_txn(input int ad, input int pt, input bit dec, input int w,
                           input bit hold, input int extra_start, input int abort_at);
        int t;
        int wait_cnt;
        bit prev_ciph;
        bit ended;
        r_tag_t = 0; r_end_t = 0; r_ciph = 0; r_cv = 0; r_cv_ok = 0; r_lsb = 0;
        r_lsb_key = 0; r_ready = 0; r_loads = 0; r_bad_load = 0; r_busy = 0; r_dec = 0;
        r_abort_round = 0; r_seq = '0; r_abort_outs = '1;
        nb_ad_i      = BLOCK_W'(ad);
        nb_pt_i      = BLOCK_W'(pt);
        decrypt_i    = dec;
        start_i      = 1'b1;
        data_valid_i = hold;
        @(posedge clock_i);
        @(negedge clock_i);
        t = 2;
        start_i   = 1'b0;
        decrypt_i = ~dec;
        nb_ad_i   = BLOCK_W'(ad + 1);
        nb_pt_i   = BLOCK_W'(pt + 2);
        wait_cnt  = 0;
        prev_ciph = 1'b0;
        ended     = 1'b0;
        r_busy_t2 = busy_o;
        r_end_t2  = end_o;
        while (!ended && t < 400) begin
            if (abort_at != 0 && t == abort_at + 1) begin
                r_abort_outs = all_outs;
                ended = 1'b1;
            end else begin
                if (abort_at != 0 && t == abort_at) r_abort_round = int'(round_o);
                if (en_tag_o) r_tag_t = t;
                if (en_cipher_o) r_ciph++;
                if (cipher_valid_o) r_cv++;
                if (cipher_valid_o && prev_ciph) r_cv_ok++;
                prev_ciph = en_cipher_o;
                if (en_xor_lsb_o) r_lsb++;
                if (en_xor_lsb_o && en_xor_key_end_o) r_lsb_key++;
                if (data_ready_o) r_ready++;
                if (en_reg_state_o) r_loads++;
                if (data_ready_o && en_reg_state_o) r_bad_load++;
                if (en_xor_data_o) r_seq = {r_seq[27:0], 4'(block_o)};
                if (busy_o) r_busy++;
                if (busy_o && decrypt_mode_o) r_dec++;
                if (end_o) begin
                    r_end_t = t;
                    ended = 1'b1;
                end
            end
            if (!ended) begin
                if (hold) begin
                    data_valid_i = 1'b1;
                end else if (!data_ready_o) begin
                    data_valid_i = 1'b0;
                    wait_cnt = 0;
                end else begin
                    data_valid_i = (wait_cnt >= w);
                    wait_cnt++;
                end
                start_i = (t == extra_start);
                abort_i = (abort_at != 0) && (t == abort_at);
                @(posedge clock_i);
                @(negedge clock_i);
                t++;
            end
        end
        r_timeout    = !ended;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        data_valid_i = 1'b0;
    endtask

    task automatic check_run(input string tag, input int exp_tag, input int exp_end,
                             input int exp_ciph, input int exp_lsb, input int exp_lsb_key,
                             input int exp_ready, input int exp_loads, input logic [31:0] exp_seq);
        check_eq({tag, "_timeout"}, 32'(r_timeout), 32'd0);
        check_eq({tag, "_tag_cycle"}, r_tag_t, exp_tag);
        check_eq({tag, "_end_cycle"}, r_end_t, exp_end);
        check_eq({tag, "_cipher_pulses"}, r_ciph, exp_ciph);
        check_eq({tag, "_cipher_valid"}, r_cv, exp_ciph);
        check_eq({tag, "_cipher_valid_lag"}, r_cv_ok, exp_ciph);
        check_eq({tag, "_lsb_pulses"}, r_lsb, exp_lsb);
        check_eq({tag, "_lsb_with_key_end"}, r_lsb_key, exp_lsb_key);
        check_eq({tag, "_ready_cycles"}, r_ready, exp_ready);
        check_eq({tag, "_state_loads"}, r_loads, exp_loads);
        check_eq({tag, "_load_while_ready"}, r_bad_load, 0);
        check_eq({tag, "_block_seq"}, r_seq, exp_seq);
        check_eq({tag, "_end_drops"}, 32'(r_end_t2), 32'd0);
        check_eq({tag, "_busy_rises"}, 32'(r_busy_t2), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetb_i = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        decrypt_i = 1'b0;
        nb_ad_i = '0;
        nb_pt_i = '0;
        data_valid_i = 1'b0;
        repeat (3) @(negedge clock_i);
        check_eq("reset_outs", all_outs, 32'd0);
        resetb_i = 1'b1;
        @(negedge clock_i);
        check_eq("idle_outs", all_outs, 32'd0);

        // Defaults: 12 + 1 + 6 + 1 + 12 busy cycles, tag at 33, end at 34.
        run_txn(1, 1, 1'b0, 0, 1'b1, 0, 0);
        check_run("ad1_pt1", 33, 34, 1, 1, 0, 2, 30, 32'h00);
        check_eq("ad1_pt1_dec_cycles", r_dec, 0);

        // No AD: lsb lands with the INIT key-end; PT blocks 0,1 then FINAL block 2.
        run_txn(0, 3, 1'b0, 0, 1'b1, 0, 0);
        check_run("ad0_pt3", 40, 41, 3, 1, 1, 3, 36, 32'h012);

        // Five idle cycles in every wait: 4 waits of 6 ready cycles each.
        run_txn(2, 2, 1'b0, 5, 1'b0, 0, 0);
        check_run("ad2_pt2_wait", 67, 68, 2, 1, 0, 24, 42, 32'h0101);

        // Decrypt: same timing as encryption, mode held for every busy cycle.
        run_txn(1, 1, 1'b1, 0, 1'b1, 0, 0);
        check_run("decrypt", 33, 34, 1, 1, 0, 2, 30, 32'h00);
        check_eq("decrypt_busy_cycles", r_busy, 32);
        check_eq("decrypt_mode_cycles", r_dec, 32);
        check_eq("decrypt_mode_in_done", 32'(decrypt_mode_o), 32'd1);

        // nb_pt of 0 behaves as a single (final) block.
        run_txn(0, 0, 1'b0, 0, 1'b1, 0, 0);
        check_run("ad0_pt0", 26, 27, 1, 1, 1, 1, 24, 32'h0);

        // Abort in the third round of the first PT block.
        run_txn(0, 3, 1'b0, 0, 1'b1, 0, 17);
        check_eq("abort_timeout", 32'(r_timeout), 32'd0);
        check_eq("abort_in_pt_round", r_abort_round, 8);
        check_eq("abort_outs", r_abort_outs, 32'd0);
        run_txn(1, 1, 1'b0, 0, 1'b1, 0, 0);
        check_run("after_abort", 33, 34, 1, 1, 0, 2, 30, 32'h00);

        // Asynchronous reset in the middle of INIT.
        nb_ad_i = BLOCK_W'(1);
        nb_pt_i = BLOCK_W'(1);
        start_i = 1'b1;
        data_valid_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (4) @(negedge clock_i);
        check_eq("pre_reset_in_init", 32'(en_reg_state_o), 32'd1);
        resetb_i = 1'b0;
        #1;
        check_eq("async_reset_outs", all_outs, 32'd0);
        @(negedge clock_i);
        resetb_i = 1'b1;
        data_valid_i = 1'b0;
        @(negedge clock_i);
        check_eq("post_reset_idle", all_outs, 32'd0);

        // Extra start while busy is ignored.
        run_txn(1, 1, 1'b0, 0, 1'b1, 10, 0);
        check_run("busy_start", 33, 34, 1, 1, 0, 2, 30, 32'h00);
        repeat (3) @(negedge clock_i);
        check_eq("done_held", 32'(end_o), 32'd1);

        // Restart from DONE.
        run_txn(2, 1, 1'b0, 0, 1'b1, 0, 0);
        check_run("restart", 40, 41, 1, 1, 0, 3, 36, 32'h010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
